// File: rtl/instr_sequencer.sv
// ============================================================================
// Module   : instr_sequencer
// Function : PDP-8 major-state sequencer (fetch/defer/autoindex/execute) that
//            issues memory handshakes and datapath load/select strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_sequencer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RUN,
  input  logic       AAND,
  input  logic       TAD,
  input  logic       ISZ,
  input  logic       DCA,
  input  logic       JMS,
  input  logic       JMP,
  input  logic       IOT,
  input  logic       OPR,
  input  logic       IND,
  input  logic       PPIND,
  input  logic       MEMACK,
  input  logic       ISZCARRY,
  input  logic       IOTACK,
  output logic       MEMREQ,
  output logic       MEMWR,
  output logic       MASEL,
  output logic [1:0] WDSEL,
  output logic       LDIR,
  output logic       LDMD,
  output logic       LDEA,
  output logic [1:0] EASEL,
  output logic       INCPC,
  output logic       LDPC,
  output logic       ANDSTB,
  output logic       TADSTB,
  output logic       CLRAC,
  output logic       OPRSTB,
  output logic       IOTREQ,
  output logic [3:0] STATE
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_DEFER   = 4'd3,
    S_AUTOINC = 4'd4,
    S_EXEC    = 4'd5,
    S_ISZW    = 4'd6,
    S_JMS2    = 4'd7,
    S_OPRX    = 4'd8,
    S_IOTX    = 4'd9
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t w_end_state;
  logic   w_mem_ack;
  logic   w_iot_ack;

  // Acknowledges arriving while reset is sampled must not fire any strobe.
  assign w_mem_ack   = MEMACK & ~RESET;
  assign w_iot_ack   = IOTACK & ~RESET;
  assign w_end_state = RUN ? S_FETCH : S_IDLE;
  assign STATE       = state_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    MEMREQ  = 1'b0;
    MEMWR   = 1'b0;
    MASEL   = 1'b0;
    WDSEL   = 2'd0;
    LDIR    = 1'b0;
    LDMD    = 1'b0;
    LDEA    = 1'b0;
    EASEL   = 2'd0;
    INCPC   = 1'b0;
    LDPC    = 1'b0;
    ANDSTB  = 1'b0;
    TADSTB  = 1'b0;
    CLRAC   = 1'b0;
    OPRSTB  = 1'b0;
    IOTREQ  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH;
      end

      S_FETCH: begin
        MEMREQ = 1'b1;
        if (w_mem_ack) begin
          LDIR    = 1'b1;
          INCPC   = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        LDEA = 1'b1;
        if (OPR) begin
          state_d = S_OPRX;
        end else if (IOT) begin
          state_d = S_IOTX;
        end else if (IND || PPIND) begin
          state_d = S_DEFER;
        end else if (JMP) begin
          // Direct EA is combinational, so PC can take it on this same edge.
          LDPC    = 1'b1;
          state_d = w_end_state;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_DEFER: begin
        MEMREQ = 1'b1;
        MASEL  = 1'b1;
        if (w_mem_ack) begin
          LDMD = 1'b1;
          if (PPIND) begin
            state_d = S_AUTOINC;
          end else begin
            LDEA    = 1'b1;
            EASEL   = 2'd1;
            state_d = S_EXEC;
          end
        end
      end

      S_AUTOINC: begin
        MEMREQ = 1'b1;
        MEMWR  = 1'b1;
        MASEL  = 1'b1;
        if (w_mem_ack) begin
          LDEA    = 1'b1;
          EASEL   = 2'd2;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (JMP) begin
          LDPC    = 1'b1;
          state_d = w_end_state;
        end else if (AAND || TAD) begin
          MEMREQ = 1'b1;
          MASEL  = 1'b1;
          if (w_mem_ack) begin
            LDMD    = 1'b1;
            ANDSTB  = AAND;
            TADSTB  = TAD;
            state_d = w_end_state;
          end
        end else if (ISZ) begin
          MEMREQ = 1'b1;
          MASEL  = 1'b1;
          if (w_mem_ack) begin
            LDMD    = 1'b1;
            state_d = S_ISZW;
          end
        end else if (DCA) begin
          MEMREQ = 1'b1;
          MEMWR  = 1'b1;
          MASEL  = 1'b1;
          WDSEL  = 2'd1;
          if (w_mem_ack) begin
            CLRAC   = 1'b1;
            state_d = w_end_state;
          end
        end else if (JMS) begin
          MEMREQ = 1'b1;
          MEMWR  = 1'b1;
          MASEL  = 1'b1;
          WDSEL  = 2'd2;
          if (w_mem_ack) begin
            LDPC    = 1'b1;
            state_d = S_JMS2;
          end
        end else begin
          state_d = w_end_state;
        end
      end

      S_ISZW: begin
        MEMREQ = 1'b1;
        MEMWR  = 1'b1;
        MASEL  = 1'b1;
        if (w_mem_ack) begin
          INCPC   = ISZCARRY;
          state_d = w_end_state;
        end
      end

      S_JMS2: begin
        INCPC   = 1'b1;
        state_d = w_end_state;
      end

      S_OPRX: begin
        OPRSTB  = 1'b1;
        state_d = w_end_state;
      end

      S_IOTX: begin
        IOTREQ = 1'b1;
        if (w_iot_ack) state_d = w_end_state;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module   : tb_instr_sequencer
// Function : Directed self-checking bench for instr_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

  logic       CLK;
  logic       RESET, RUN;
  logic       AAND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR, IND, PPIND;
  logic       MEMACK, ISZCARRY, IOTACK;
  logic       MEMREQ, MEMWR, MASEL, LDIR, LDMD, LDEA, INCPC, LDPC;
  logic       ANDSTB, TADSTB, CLRAC, OPRSTB, IOTREQ;
  logic [1:0] WDSEL, EASEL;
  logic [3:0] STATE;

  instr_sequencer dut (
    .CLK(CLK), .RESET(RESET), .RUN(RUN),
    .AAND(AAND), .TAD(TAD), .ISZ(ISZ), .DCA(DCA), .JMS(JMS), .JMP(JMP),
    .IOT(IOT), .OPR(OPR), .IND(IND), .PPIND(PPIND),
    .MEMACK(MEMACK), .ISZCARRY(ISZCARRY), .IOTACK(IOTACK),
    .MEMREQ(MEMREQ), .MEMWR(MEMWR), .MASEL(MASEL), .WDSEL(WDSEL),
    .LDIR(LDIR), .LDMD(LDMD), .LDEA(LDEA), .EASEL(EASEL),
    .INCPC(INCPC), .LDPC(LDPC), .ANDSTB(ANDSTB), .TADSTB(TADSTB),
    .CLRAC(CLRAC), .OPRSTB(OPRSTB), .IOTREQ(IOTREQ), .STATE(STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed vector: {STATE, MEMREQ, MEMWR, MASEL, WDSEL, LDIR, LDMD, LDEA,
  //                   EASEL, INCPC, LDPC, ANDSTB, TADSTB, CLRAC, OPRSTB, IOTREQ}
  logic [20:0] obs;
  assign obs = {STATE, MEMREQ, MEMWR, MASEL, WDSEL, LDIR, LDMD, LDEA,
                EASEL, INCPC, LDPC, ANDSTB, TADSTB, CLRAC, OPRSTB, IOTREQ};

  localparam logic [16:0] REQ  = 17'h10000;
  localparam logic [16:0] WR   = 17'h08000;
  localparam logic [16:0] MA   = 17'h04000;
  localparam logic [16:0] WD2  = 17'h02000;
  localparam logic [16:0] WD1  = 17'h01000;
  localparam logic [16:0] LIR  = 17'h00800;
  localparam logic [16:0] LMD  = 17'h00400;
  localparam logic [16:0] LEA  = 17'h00200;
  localparam logic [16:0] ES2  = 17'h00100;
  localparam logic [16:0] ES1  = 17'h00080;
  localparam logic [16:0] INC  = 17'h00040;
  localparam logic [16:0] LPC  = 17'h00020;
  localparam logic [16:0] ANDS = 17'h00010;
  localparam logic [16:0] TADS = 17'h00008;
  localparam logic [16:0] CLR  = 17'h00004;
  localparam logic [16:0] OPS  = 17'h00002;
  localparam logic [16:0] IOQ  = 17'h00001;

  // Per-cycle control nibble: {RUN, RESET, IOTACK, MEMACK}
  localparam logic [3:0] C_RUN = 4'b1000;
  localparam logic [3:0] C_ACK = 4'b1001;
  localparam logic [3:0] C_IOA = 4'b1011;

  localparam logic [16:0] FETCH_ACK = REQ | LIR | INC;

  int          checks = 0;
  int          errors = 0;
  logic [20:0] ex    [16];
  logic [3:0]  ctl_v [16];

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_v(input int i, input logic [3:0] ctl, input logic [3:0] st,
                       input logic [16:0] m);
    ex[i]    = {st, m};
    ctl_v[i] = ctl;
  endtask

  // op order: {AAND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR}
  task automatic set_op(input logic [7:0] op, input logic ind, input logic ppind,
                        input logic carry);
    {AAND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR} = op;
    IND      = ind;
    PPIND    = ppind;
    ISZCARRY = carry;
  endtask

  // Leaves the DUT in IDLE with RESET released, just after a rising edge.
  task automatic do_reset();
    RESET = 1'b1; MEMACK = 1'b0; IOTACK = 1'b0;
    cyc();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    set_op(8'b0100_0000, 1'b0, 1'b0, 1'b0);
    RUN = 1'b1; MEMACK = 1'b0; IOTACK = 1'b0;
    RESET = 1'b1;
    cyc();
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL reset_hold got %h exp %h", obs, 21'h0);
    end
    RESET = 1'b0;
    cyc();
    checks++;
    if (obs !== {4'd1, REQ}) begin
      errors++; $display("FAIL reset_release got %h exp %h", obs, {4'd1, REQ});
    end
    // Reset mid-access with a coincident MEMACK: no LDIR, IDLE next cycle.
    RESET = 1'b1; MEMACK = 1'b1;
    #1;
    checks++;
    if (obs !== {4'd1, REQ}) begin
      errors++; $display("FAIL reset_ack_ignored got %h exp %h", obs, {4'd1, REQ});
    end
    cyc();
    checks++;
    if (obs !== 21'h0) begin
      errors++; $display("FAIL reset_mid_access got %h exp %h", obs, 21'h0);
    end
    RESET = 1'b0; MEMACK = 1'b0;
  endtask

  task automatic test_tad_and();
    set_op(8'b0100_0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    set_v(3, C_ACK, 4'd5, REQ | MA | LMD | TADS);
    set_v(4, C_ACK, 4'd1, FETCH_ACK);
    for (int i = 0; i < 5; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL tad_direct cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
    // AND with one wait cycle in EXEC: controls hold, strobe only on MEMACK.
    set_op(8'b1000_0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    set_v(3, C_RUN, 4'd5, REQ | MA);
    set_v(4, C_ACK, 4'd5, REQ | MA | LMD | ANDS);
    set_v(5, C_RUN, 4'd1, REQ);
    for (int i = 0; i < 6; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL and_wait cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
  endtask

  task automatic test_fetch_wait();
    set_op(8'b0100_0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_RUN, 4'd0, 17'h0);
    set_v(1, C_RUN, 4'd1, REQ);
    set_v(2, C_RUN, 4'd1, REQ);
    set_v(3, C_RUN, 4'd1, REQ);
    set_v(4, C_ACK, 4'd1, FETCH_ACK);
    set_v(5, C_ACK, 4'd2, LEA);
    for (int i = 0; i < 6; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL fetch_wait cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
  endtask

  task automatic test_jmp();
    // JMP I via autoindex location
    set_op(8'b0000_0100, 1'b0, 1'b1, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    set_v(3, C_ACK, 4'd3, REQ | MA | LMD);
    set_v(4, C_ACK, 4'd4, REQ | WR | MA | LEA | ES2);
    set_v(5, C_ACK, 4'd5, LPC);
    set_v(6, C_ACK, 4'd1, FETCH_ACK);
    for (int i = 0; i < 7; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL jmp_autoinc cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
    // JMP direct: two cycles, LDPC alongside LDEA in DECODE
    set_op(8'b0000_0100, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA | LPC);
    set_v(3, C_ACK, 4'd1, FETCH_ACK);
    for (int i = 0; i < 4; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL jmp_direct cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
    // TAD I (plain indirect): DEFER loads EA from MD
    set_op(8'b0100_0000, 1'b1, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    set_v(3, C_ACK, 4'd3, REQ | MA | LMD | LEA | ES1);
    set_v(4, C_ACK, 4'd5, REQ | MA | LMD | TADS);
    set_v(5, C_ACK, 4'd1, FETCH_ACK);
    for (int i = 0; i < 6; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL tad_indirect cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
  endtask

  task automatic test_isz();
    for (int c = 0; c < 2; c++) begin
      set_op(8'b0010_0000, 1'b0, 1'b0, (c == 0));
      do_reset();
      set_v(0, C_ACK, 4'd0, 17'h0);
      set_v(1, C_ACK, 4'd1, FETCH_ACK);
      set_v(2, C_ACK, 4'd2, LEA);
      set_v(3, C_ACK, 4'd5, REQ | MA | LMD);
      set_v(4, C_ACK, 4'd6, (c == 0) ? (REQ | WR | MA | INC) : (REQ | WR | MA));
      set_v(5, C_ACK, 4'd1, FETCH_ACK);
      for (int i = 0; i < 6; i++) begin
        {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
        #1;
        checks++;
        if (obs !== ex[i]) begin
          errors++;
          $display("FAIL isz carry=%0d cyc%0d got %h exp %h", 1 - c, i, obs, ex[i]);
        end
        cyc();
      end
    end
  endtask

  task automatic test_jms_dca();
    set_op(8'b0000_1000, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    set_v(3, C_ACK, 4'd5, REQ | WR | MA | WD2 | LPC);
    set_v(4, C_ACK, 4'd7, INC);
    set_v(5, C_ACK, 4'd1, FETCH_ACK);
    for (int i = 0; i < 6; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL jms cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
    set_op(8'b0001_0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    set_v(3, C_ACK, 4'd5, REQ | WR | MA | WD1 | CLR);
    set_v(4, C_ACK, 4'd1, FETCH_ACK);
    for (int i = 0; i < 5; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL dca cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
  endtask

  task automatic test_opr_stop();
    // RUN drops during OPRX: instruction completes, then IDLE.
    set_op(8'b0000_0001, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, 4'b0001, 4'd2, LEA);
    set_v(3, 4'b0001, 4'd8, OPS);
    set_v(4, 4'b0001, 4'd0, 17'h0);
    set_v(5, 4'b0001, 4'd0, 17'h0);
    for (int i = 0; i < 6; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL opr_stop cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
  endtask

  task automatic test_iot();
    // IOTACK on the 6th IOTX cycle; MEMACK held high and must be ignored.
    set_op(8'b0000_0010, 1'b0, 1'b0, 1'b0);
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    for (int k = 3; k < 8; k++) set_v(k, C_ACK, 4'd9, IOQ);
    set_v(8, C_IOA, 4'd9, IOQ);
    set_v(9, C_RUN, 4'd1, REQ);
    for (int i = 0; i < 10; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL iot_wait cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
    // RESET with a coincident IOTACK in IOTX's 3rd cycle.
    do_reset();
    set_v(0, C_ACK, 4'd0, 17'h0);
    set_v(1, C_ACK, 4'd1, FETCH_ACK);
    set_v(2, C_ACK, 4'd2, LEA);
    set_v(3, C_RUN, 4'd9, IOQ);
    set_v(4, C_RUN, 4'd9, IOQ);
    set_v(5, 4'b1110, 4'd9, IOQ);
    set_v(6, C_RUN, 4'd0, 17'h0);
    set_v(7, C_RUN, 4'd1, REQ);
    for (int i = 0; i < 8; i++) begin
      {RUN, RESET, IOTACK, MEMACK} = ctl_v[i];
      #1;
      checks++;
      if (obs !== ex[i]) begin
        errors++; $display("FAIL iot_reset cyc%0d got %h exp %h", i, obs, ex[i]);
      end
      cyc();
    end
  endtask

  initial begin
    RESET = 1'b1; RUN = 1'b0; MEMACK = 1'b0; IOTACK = 1'b0;
    set_op(8'h00, 1'b0, 1'b0, 1'b0);
    cyc();
    test_reset();
    test_tad_and();
    test_fetch_wait();
    test_jmp();
    test_isz();
    test_jms_dca();
    test_opr_stop();
    test_iot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
# instr_sequencer

Major-state sequencer for the PDP-8 CPU. It drives fetch, defer, autoindex and execute cycles from the instruction-decoder outputs (AAND…OPR, IND, PPIND, DIR). It generates the memory request handshake and the datapath load and select strobes that move PC, IR, MA/EA, MD and AC. It sits between the IR decoder, the shared memory port and the AC/PC datapath.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on the rising edge
- RESET  in  1  synchronous, active-high; one clock; forces IDLE
- RUN  in  1  level; allows a new fetch to start
- AAND, TAD, ISZ, DCA, JMS, JMP, IOT, OPR  in  1 each  one-hot opcode from the IR decoder
- IND, PPIND  in  1 each  indirect; indirect via page-0 autoindex location 0010–0017
- MEMACK  in  1  memory completes the current request this cycle (read data valid)
- ISZCARRY  in  1  datapath MD==7777 (MD+1 wraps to 0000)
- IOTACK  in  1  device finished the IOT
- MEMREQ  out  1  memory request
- MEMWR  out  1  1=write, 0=read; valid while MEMREQ
- MASEL  out  1  address source: 0=PC, 1=EA
- WDSEL  out  2  write data: 0=MD+1, 1=AC, 2=PC
- LDIR  out  1  IR ← read data
- LDMD  out  1  MD ← read data
- LDEA  out  1  EA ← per EASEL
- EASEL  out  2  0=direct (IR page/offset), 1=MD, 2=MD+1
- INCPC  out  1  PC ← PC+1
- LDPC  out  1  PC ← EA
- ANDSTB, TADSTB  out  1 each  AC ← AC&MD / AC+MD (with link)
- CLRAC  out  1  AC ← 0 (DCA)
- OPRSTB  out  1  execute operate microcode, one cycle
- IOTREQ  out  1  IOT in progress
- STATE  out  4  current state code (debug)

## Operation
- States and codes: IDLE 0, FETCH 1, DECODE 2, DEFER 3, AUTOINC 4, EXEC 5, ISZW 6, JMS2 7, OPRX 8, IOTX 9. Codes 10–15 are unused and go to IDLE.
- IDLE: every output is 0. Go to FETCH if RUN.
- FETCH: MEMREQ=1, MEMWR=0, MASEL=0. In the MEMACK cycle assert LDIR and INCPC, then go to DECODE.
- DECODE: LDEA=1, EASEL=0 (EA ← direct address). Next state:
  - OPR → OPRX.
  - IOT → IOTX.
  - IND or PPIND → DEFER.
  - JMP (direct) → assert LDPC in the same cycle, then end instruction. Direct EA is combinational and valid for this load.
  - Otherwise → EXEC.
- DEFER: read at EA (MASEL=1). On MEMACK assert LDMD.
  - If PPIND → AUTOINC.
  - Else assert LDEA with EASEL=1, then JMP → JMS2-free path: assert LDPC the next cycle via EXEC rule below; others → EXEC.
- AUTOINC: write MD+1 to EA (MEMWR=1, MASEL=1, WDSEL=0). On MEMACK assert LDEA with EASEL=2, then go to EXEC.
- EXEC, by opcode:
  - JMP: LDPC for one cycle with no memory access, then end.
  - AAND/TAD: read EA. On MEMACK assert LDMD, plus ANDSTB or TADSTB, then end.
  - ISZ: read EA. On MEMACK assert LDMD, go to ISZW.
  - DCA: write AC (WDSEL=1). On MEMACK assert CLRAC, then end.
  - JMS: write PC (WDSEL=2). On MEMACK assert LDPC, go to JMS2.
- ISZW: write MD+1 to EA. On MEMACK assert INCPC if ISZCARRY (skip), then end.
- JMS2: INCPC for one cycle, then end.
- OPRX: OPRSTB for one cycle, then end.
- IOTX: hold IOTREQ=1 until IOTACK. In the IOTACK cycle, end.
- End instruction: go to FETCH if RUN, else IDLE. RUN is ignored inside an instruction; an instruction always completes.
- Strobes are Mealy outputs: they come from state & MEMACK / IOTACK in the same cycle, and the datapath captures them on the closing edge.

## Timing
- Handshake:
  - MEMREQ, MEMWR, MASEL and WDSEL stay constant from the request cycle until and including the MEMACK cycle.
  - MEMREQ drops on the next cycle unless the next state issues a new request.
  - MEMACK while MEMREQ=0 is ignored.
- Cycle counts with zero-wait memory (MEMACK held 1):
  - JMP direct 2; OPR 3; TAD/AND/DCA direct 3; JMS 4; ISZ 4.
  - Indirect adds 1; autoindex adds 2.
  - Each memory wait cycle adds 1.
- LDEA from DECODE is visible to MASEL=1 accesses from the next cycle onward.
- RESET:
  - Synchronous, active-high; one clock.
  - The next state is IDLE with all outputs 0, including mid-access (MEMREQ low the cycle after RESET is sampled) and mid-IOT (IOTREQ drops).
  - A MEMACK or IOTACK arriving during RESET is ignored.
- RESET has priority over RUN, MEMACK and IOTACK.

## Test plan
- Reset: assert RESET with RUN=1 → every output 0 and STATE=0. On release, MEMREQ=1, MASEL=0 the next cycle.
- TAD direct, MEMACK=1 constant → STATE sequence 1,2,5,1. LDIR+INCPC in cycle 1, LDEA/EASEL=0 in cycle 2, LDMD+TADSTB in cycle 3.
- Fetch with 3 wait cycles (MEMACK low for 3 cycles) → MEMREQ held 4 cycles with stable controls. LDIR only in the 4th.
- JMP I 0010 (PPIND=1) → DEFER read, then AUTOINC write with WDSEL=0, then EXEC with LDPC. STATE sequence 1,2,3,4,5,1.
- ISZ with ISZCARRY=1 → ISZW write asserts INCPC in its MEMACK cycle. With ISZCARRY=0 there is no INCPC.
- IOT with IOTACK delayed 5 cycles → IOTREQ high for 6 cycles. RESET asserted in IOTX's 3rd cycle → IDLE next cycle and IOTREQ=0.
